axis_pkt_gen: RTL and testbench

- AXI4-Stream packet source that feeds the 256-bit datapath input of the top-level simulation and bring-up build.
- Emits a programmed number of fixed-length Ethernet-sized packets with a deterministic byte pattern and NetFPGA-style tuser metadata.
- Supports a configurable inter-packet gap and honours downstream backpressure.
- Reports progress so benches and the host can pace traffic.

---
 rtl/axis_pkt_gen.sv | 96 +++++++++
 tb/tb_axis_pkt_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream packet source with fixed-length patterned packets, inter-packet gap and stop control
module axis_pkt_gen #(
  parameter int C_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH = 128,
  parameter logic [7:0] SRC_PORT = 8'h01,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 9600
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rst,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [15:0]               cfg_pkt_len,
  input  logic [31:0]               cfg_pkt_cnt,
  input  logic [15:0]               cfg_ipg,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_USER_WIDTH-1:0]   m_axis_tuser,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               pkts_sent
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t state, state_nx;
  logic [15:0] len_r, ipg_r, gap_cnt, beat, last_beat, eff_len;
  logic [31:0] cnt_r;
  logic [4:0] lane_m1;
  logic stop_pend, stop_any, last_pkt, xfer, is_last;
  assign eff_len = cfg_pkt_len < 16'(MIN_LEN) ? 16'(MIN_LEN) :
                   cfg_pkt_len > 16'(MAX_LEN) ? 16'(MAX_LEN) : cfg_pkt_len;
  assign last_beat = ((len_r + 16'd31) >> 5) - 16'd1;
  // valid lanes on the final beat minus one; zero residue means a full beat
  assign lane_m1 = 5'(len_r - 16'd1);
  assign is_last = state == SEND && beat == last_beat;
  assign xfer = state == SEND && m_axis_tready;
  assign stop_any = stop_pend | cfg_stop;
  assign last_pkt = pkts_sent + 32'd1 == cnt_r;
  always_ff @(posedge axis_aclk)
    state <= axis_rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cfg_start ? (cfg_pkt_cnt == 32'd0 ? FIN : SEND) : IDLE;
      SEND: state_nx = !(xfer && is_last) ? SEND :
                       (last_pkt || stop_any) ? FIN :
                       ipg_r != 16'd0 ? GAP : SEND;
      GAP:  state_nx = stop_any ? FIN : gap_cnt == ipg_r - 16'd1 ? SEND : GAP;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      len_r <= '0;
      ipg_r <= '0;
      cnt_r <= '0;
      gap_cnt <= '0;
      beat <= '0;
      stop_pend <= 1'b0;
      pkts_sent <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FIN;
      stop_pend <= state != IDLE && stop_any;
      gap_cnt <= state == GAP ? gap_cnt + 16'd1 : 16'd0;
      if (state == IDLE && cfg_start) begin
        len_r <= eff_len;
        cnt_r <= cfg_pkt_cnt;
        ipg_r <= cfg_ipg;
        pkts_sent <= '0;
        beat <= '0;
      end else if (xfer) begin
        beat <= is_last ? 16'd0 : beat + 16'd1;
        if (is_last) pkts_sent <= pkts_sent + 32'd1;
      end
    end
  end
  always_comb begin
    busy = state != IDLE;
    m_axis_tvalid = state == SEND;
    m_axis_tlast = is_last;
    m_axis_tuser = '0;
    m_axis_tuser[15:0] = state == SEND ? len_r : 16'd0;
    m_axis_tuser[23:16] = state == SEND ? SRC_PORT : 8'd0;
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    // pattern byte = pkt_idx + 32*beat + lane, so beat only matters mod 8
    for (int k = 0; k < C_DATA_WIDTH / 8; k++) begin
      m_axis_tkeep[k] = state == SEND && (!is_last || 5'(k) <= lane_m1);
      m_axis_tdata[8*k +: 8] = state == SEND ? pkts_sent[7:0] + {beat[2:0], 5'd0} + 8'(k) : 8'd0;
    end
  end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: randomized scoreboard bench for axis_pkt_gen
module tb_axis_pkt_gen;
  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [127:0] u;
  } beat_t;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_stop = 0, tready = 1;
  logic [15:0] cfg_pkt_len = 0, cfg_ipg = 0;
  logic [31:0] cfg_pkt_cnt = 0;
  logic [255:0] tdata;
  logic [31:0] tkeep;
  logic [127:0] tuser;
  logic tvalid, tlast, busy, done;
  logic [31:0] pkts_sent;
  int errors = 0, checks = 0, xfers = 0, tlasts = 0, exp_ipg = 0, gap_n = 0;
  bit rand_ready = 0, in_pkt = 0, gap_on = 0, stall_prev = 0;
  beat_t exp_q[$];
  beat_t mon_e, held;
  axis_pkt_gen dut (
    .axis_aclk(clk), .axis_rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_cnt(cfg_pkt_cnt), .cfg_ipg(cfg_ipg),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
    .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [255:0] lane_mask(input logic [31:0] k);
    logic [255:0] m = '0;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction
  // reference: packet p, byte j of the packet (j = 32*b + lane) carries (p + j) mod 256
  task automatic push_pkts(input int len, input int n);
    int eff, nb;
    beat_t e;
    eff = len < 60 ? 60 : len > 9600 ? 9600 : len;
    nb = (eff + 31) / 32;
    for (int p = 0; p < n; p++)
      for (int b = 0; b < nb; b++) begin
        e.d = '0;
        e.k = '0;
        for (int i = 0; i < 32; i++)
          if (32 * b + i < eff) begin
            e.k[i] = 1'b1;
            e.d[8*i +: 8] = 8'((p + 32 * b + i) % 256);
          end
        e.l = b == nb - 1;
        e.u = '0;
        e.u[15:0] = 16'(eff);
        e.u[23:16] = 8'h01;
        exp_q.push_back(e);
      end
  endtask
  initial forever begin
    @(posedge clk);
    #1 tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0;
      gap_on = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, held.d);
        chk("hold_keep", tkeep, held.k);
        chk("hold_last", tlast, held.l);
        chk("hold_user", tuser, held.u);
      end
      stall_prev = tvalid && !tready;
      held = '{tdata, tkeep, tlast, tuser};
      if (in_pkt) chk("no_valid_drop", tvalid, 1);
      if (gap_on) begin
        if (tvalid) begin
          chk("ipg_cycles", gap_n, exp_ipg);
          gap_on = 0;
        end else gap_n++;
      end
      if (tvalid && tready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", tdata & lane_mask(mon_e.k), mon_e.d);
          chk("tkeep", tkeep, mon_e.k);
          chk("tlast", tlast, mon_e.l);
          chk("tuser", tuser, mon_e.u);
        end
        if (tlast) begin
          tlasts++;
          in_pkt = 0;
          gap_on = 1;
          gap_n = 0;
        end else in_pkt = 1;
      end
      if (done) gap_on = 0;
    end
  end
  task automatic start_run(input int len, input int cnt, input int ipg, input int npush);
    @(posedge clk);
    #1;
    cfg_pkt_len = 16'(len);
    cfg_pkt_cnt = 32'(cnt);
    cfg_ipg = 16'(ipg);
    exp_ipg = ipg;
    push_pkts(len, npush);
    cfg_start = 1;
    @(posedge clk);
    #1 cfg_start = 0;
    cfg_pkt_len = 16'($urandom);
    cfg_pkt_cnt = $urandom;
    cfg_ipg = 16'($urandom);
    @(negedge clk);
    chk("start_latency_tvalid", tvalid, cnt != 0);
    chk("start_busy", busy, 1);
  endtask
  task automatic wait_done(input int exp_pkts, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20000);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20000 cycles");
    end else begin
      chk("busy_at_done", busy, 0);
      chk("pkts_sent", pkts_sent, exp_pkts);
      chk("scoreboard_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("done_single", done, 0);
    end
  endtask
  initial begin
    int n, x0, t0;
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end
  initial begin
    int n, x0, t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkts", pkts_sent, 0);
    chk("rst_tkeep", tkeep, 0);
    @(posedge clk);
    #1 rst = 0;
    start_run(64, 1, 0, 1);
    wait_done(1, n);
    start_run(100, 2, 0, 2);
    wait_done(2, n);
    start_run(10, 2, 1, 2);
    wait_done(2, n);
    start_run(64, 0, 0, 0);
    chk("zero_no_done_yet", done, 0);
    wait_done(0, n);
    chk("zero_done_latency", n, 1);
    rand_ready = 1;
    x0 = xfers;
    start_run(128, 3, 0, 3);
    wait_done(3, n);
    chk("bp_transfers", xfers - x0, 12);
    rand_ready = 0;
    t0 = tlasts;
    start_run(128, 10, 5, 3);
    n = 0;
    while (tlasts - t0 < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (!tvalid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cfg_stop = 1;
    cfg_start = 1;
    @(posedge clk);
    #1 cfg_stop = 0;
    cfg_start = 0;
    wait_done(3, n);
    start_run(128, 1, 0, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pkts", pkts_sent, 0);
    start_run(128, 1, 0, 1);
    wait_done(1, n);
    start_run(20000, 1, 0, 1);
    wait_done(1, n);
    rand_ready = 1;
    for (int i = 0; i < 4; i++) begin
      int len, cnt;
      len = $urandom_range(1, 300);
      cnt = $urandom_range(1, 3);
      start_run(len, cnt, $urandom_range(0, 3), cnt);
      wait_done(cnt, n);
    end
    rand_ready = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
